// File: rtl/cc_pkg.sv
// Shared definitions for the connected-components write-back slice.
// Contents: default widths, write-back FSM state encoding and the
// packed record layout delivered by the record FIFO ({new, old}).
package cc_pkg;

  localparam int unsigned ADDR_W_DEF          = 64;
  localparam int unsigned LABEL_W_DEF         = 32;
  localparam int unsigned MAX_OUTSTANDING_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_e;

  // Record FIFO word at default label width: new label in the upper half.
  typedef struct packed {
    logic [LABEL_W_DEF-1:0] new_label;
    logic [LABEL_W_DEF-1:0] old_label;
  } wb_rec_t;

endpackage

// File: rtl/cc_wb_outstanding_ctr.sv
// Up/down credit counter for un-acknowledged memory writes.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_inc        a write request was accepted this cycle
//   i_dec        a write acknowledgement arrived this cycle
//   o_full_next  count after this cycle's update would be >= MAX_OUTSTANDING
//   o_empty      no writes currently outstanding
module cc_wb_outstanding_ctr #(
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full_next,
  output logic o_empty
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;

  // Simultaneous accept and ack cancel; an ack with nothing in flight
  // (e.g. a write issued before a reset) is dropped instead of wrapping.
  always_comb begin
    w_count_next = r_count;
    if (i_inc && !i_dec) begin
      w_count_next = r_count + CNT_W'(1);
    end else if (i_dec && !i_inc && (r_count != '0)) begin
      w_count_next = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_full_next = (w_count_next >= CNT_W'(MAX_OUTSTANDING));
  assign o_empty     = (r_count == '0);

endmodule

// File: rtl/cc_write_back.sv
// Label write-back stage of the connected-components kernel.
// Pops one start token per pass, then consumes num_vertices (old,new) label
// records and writes new labels that differ from old ones to
// base_addr + idx*(LABEL_W/8). After all writes are acknowledged it pulses
// done and publishes update_count / changed.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   start_empty_n/read/dout       start-token FIFO (payload unused)
//   num_vertices, base_addr       pass parameters, sampled at token pop
//   rec_empty_n/read/dout         record FIFO, dout = {new_label, old_label}
//   wr_valid/ready/addr/data      write request channel
//   wr_ack                        one pulse per completed write
//   done, update_count, changed   pass result; counts held until next done
//   idle                          FSM is in IDLE
module cc_write_back
  import cc_pkg::*;
#(
  parameter int unsigned ADDR_W          = ADDR_W_DEF,
  parameter int unsigned LABEL_W         = LABEL_W_DEF,
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_empty_n,
  output logic                 start_read,
  input  logic                 start_dout,
  input  logic [31:0]          num_vertices,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic                 rec_empty_n,
  output logic                 rec_read,
  input  logic [2*LABEL_W-1:0] rec_dout,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [LABEL_W-1:0]   wr_data,
  input  logic                 wr_ack,
  output logic                 done,
  output logic [31:0]          update_count,
  output logic                 changed,
  output logic                 idle
);

  localparam int unsigned LABEL_BYTES = LABEL_W / 8;

  wb_state_e           r_state;
  wb_state_e           w_state_next;
  logic [31:0]         r_n;
  logic [31:0]         r_idx;
  logic [31:0]         r_upd;
  logic [31:0]         r_update_count;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W-1:0]   r_out_addr;
  logic [LABEL_W-1:0]  r_out_data;
  logic                r_out_valid;
  logic                r_done;
  logic                r_changed;

  logic                w_tok_pop;
  logic                w_rec_pop;
  logic                w_accept;
  logic                w_out_free;
  logic                w_more;
  logic                w_full_next;
  logic                w_ctr_empty;
  logic                w_label_changed;
  logic [LABEL_W-1:0]  w_new_label;
  logic [LABEL_W-1:0]  w_old_label;
  logic [ADDR_W-1:0]   w_rec_addr;
  logic                w_unused_start_dout;

  assign w_unused_start_dout = start_dout;

  assign w_new_label     = rec_dout[2*LABEL_W-1:LABEL_W];
  assign w_old_label     = rec_dout[LABEL_W-1:0];
  assign w_label_changed = (w_new_label != w_old_label);
  assign w_accept        = r_out_valid & wr_ready;
  assign w_out_free      = ~r_out_valid | wr_ready;
  assign w_more          = (r_idx < r_n);
  assign w_rec_addr      = r_base + (ADDR_W'(r_idx) * ADDR_W'(LABEL_BYTES));

  cc_wb_outstanding_ctr #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_outstanding (
    .clk         (clk),
    .rst_n       (reset_n),
    .i_inc       (w_accept),
    .i_dec       (wr_ack),
    .o_full_next (w_full_next),
    .o_empty     (w_ctr_empty)
  );

  always_comb begin
    w_state_next = r_state;
    w_tok_pop    = 1'b0;
    w_rec_pop    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_tok_pop = start_empty_n;
        if (start_empty_n) begin
          w_state_next = (num_vertices == 32'd0) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        // A pop needs a free (or draining) output slot and a credit that
        // survives this cycle's accept/ack update.
        w_rec_pop = rec_empty_n & w_more & w_out_free & ~w_full_next;
        if (!w_more && w_out_free) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_ctr_empty && !r_out_valid) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_n            <= '0;
      r_idx          <= '0;
      r_upd          <= '0;
      r_base         <= '0;
      r_out_addr     <= '0;
      r_out_data     <= '0;
      r_out_valid    <= 1'b0;
      r_done         <= 1'b0;
      r_update_count <= '0;
      r_changed      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_tok_pop) begin
        r_n    <= num_vertices;
        r_base <= base_addr;
        r_idx  <= '0;
        r_upd  <= '0;
      end
      if (w_rec_pop) begin
        r_idx <= r_idx + 32'd1;
        if (w_label_changed) begin
          r_out_addr <= w_rec_addr;
          r_out_data <= w_new_label;
          r_upd      <= r_upd + 32'd1;
        end
      end
      if (w_rec_pop && w_label_changed) begin
        r_out_valid <= 1'b1;
      end else if (w_accept) begin
        r_out_valid <= 1'b0;
      end
      // Result registers load on DRAIN->DONE so that done, update_count
      // and changed are all valid in the same (DONE) cycle.
      r_done <= (r_state == ST_DRAIN) && (w_state_next == ST_DONE);
      if ((r_state == ST_DRAIN) && (w_state_next == ST_DONE)) begin
        r_update_count <= r_upd;
        r_changed      <= (r_upd != 32'd0);
      end
    end
  end

  // start_read is combinational in IDLE; gating with reset_n keeps it low
  // while reset is held even if a token is waiting.
  assign start_read   = w_tok_pop & reset_n;
  assign rec_read     = w_rec_pop;
  assign wr_valid     = r_out_valid;
  assign wr_addr      = r_out_addr;
  assign wr_data      = r_out_data;
  assign done         = r_done;
  assign update_count = r_update_count;
  assign changed      = r_changed;
  assign idle         = (r_state == ST_IDLE);

endmodule
